multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter XLEN, default 64, width of the retired-instruction counter.
REQ-002 SHALL have parameter MUL_LAT, default 4, MULW wait cycles (range 1..15); used only under MC_CTRL_MUL_EN.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous and active-high.
REQ-005 opcode  in  7  instruction bits [6:0], valid while IR is stable.
REQ-006 funct7  in  7  instruction bits [31:25].
REQ-007 imem_rdy  in  1  instruction fetch response valid.
REQ-008 dmem_rdy  in  1  data access complete.
REQ-009 br_taken  in  1  branch condition from ALU, sampled in EXEC.
REQ-010 ifetch_req  out  1  fetch request.
REQ-011 IRWrite  out  1  load instruction register.
REQ-012 RegWrite  out  1  register file write enable.
REQ-013 MemRead / MemWrite  out  1 each  data memory strobes.
REQ-014 ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded.
REQ-015 ALUSrc  out  1  1 selects immediate operand.
REQ-016 MemToReg  out  1  1 selects load data for writeback.
REQ-017 PCWrite  out  1  update PC on retire; PCSrc  out  1  1 selects branch target.
REQ-018 illegal  out  1  sticky illegal-instruction flag.
REQ-019 state  out  3  current FSM state encoding.
REQ-020 instret  out  XLEN  retired-instruction count.

Function
REQ-021 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, MULW=6; 7 unreachable, SHALL recover to TRAP.
REQ-022 FETCH: ifetch_req=1; on imem_rdy pulse IRWrite for that cycle and go DECODE; else hold.
REQ-023 DECODE: classify opcode into a registered class: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011; any other opcode -> TRAP; else -> EXEC.
REQ-024 EXEC: R: ALUOp=10, ALUSrc=0 -> WB; I-ALU: ALUOp=10, ALUSrc=1 -> WB; LOAD/STORE: ALUOp=00, ALUSrc=1 -> MEM; BRANCH: ALUOp=01, PCWrite=1, PCSrc=br_taken, retire -> FETCH.
REQ-025 MEM: MemRead (LOAD) or MemWrite (STORE) held every cycle until dmem_rdy; on dmem_rdy LOAD -> WB, STORE: PCWrite=1, retire -> FETCH.
REQ-026 WB: one-cycle RegWrite=1, MemToReg=1 only for LOAD, PCWrite=1, retire -> FETCH.
REQ-027 TRAP: illegal=1, all strobes 0, remains until reset.
REQ-028 All outputs SHALL derive from registered state and class only; no combinational path from opcode/funct7 to outputs.
REQ-029 Retire SHALL increment instret by 1; wraps 2^XLEN-1 -> 0.
REQ-030 imem_rdy ignored outside FETCH; dmem_rdy ignored outside MEM; br_taken ignored outside EXEC.
REQ-031 Latency with zero wait: R/I 4 cycles, STORE 4, LOAD 5, BRANCH 3 (FETCH to next FETCH).

Reset
REQ-032 While rst high: state=FETCH, class cleared, instret=0, illegal=0, every output (including ifetch_req) 0.
REQ-033 Reset asserted mid-instruction SHALL abort it: no RegWrite, MemWrite or retire for the aborted instruction.

Configuration
REQ-034 With MC_CTRL_MUL_EN defined: R-type with funct7=0000001 goes EXEC -> MULW, waits exactly MUL_LAT cycles (ALUOp=10 held), then WB.
REQ-035 Without MC_CTRL_MUL_EN: R-type with funct7=0000001 SHALL go DECODE -> TRAP; MULW unreachable.

Verification
REQ-036 R-type 0110011, funct7=0, imem_rdy=1 -> states 0,1,2,4,0; RegWrite one cycle in WB; instret 0->1.
REQ-037 LOAD, dmem_rdy low 3 cycles in MEM -> MemRead high 4 cycles, WB with MemToReg=1, total 8 cycles.
REQ-038 BRANCH br_taken=1 -> PCWrite=1, PCSrc=1 in EXEC, no RegWrite, back to FETCH after 3 cycles.
REQ-039 opcode 1111111 -> TRAP, illegal=1 held 20 cycles; rst pulse -> illegal=0, state=FETCH.
REQ-040 funct7=0000001 R-type: macro on, MUL_LAT=4 -> 4 MULW cycles then WB; macro off -> TRAP.
REQ-041 rst asserted in MEM of STORE -> MemWrite drops immediately, instret unchanged.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM; MC_CTRL_MUL_EN enables the MULW wait state
module multicycle_control #(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode,
    input  logic [6:0]      funct7,
    input  logic            imem_rdy,
    input  logic            dmem_rdy,
    input  logic            br_taken,
    output logic            ifetch_req,
    output logic            IRWrite,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic [1:0]      ALUOp,
    output logic            ALUSrc,
    output logic            MemToReg,
    output logic            PCWrite,
    output logic            PCSrc,
    output logic            illegal,
    output logic [2:0]      state,
    output logic [XLEN-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_MULW   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_R      = 3'd1,
        C_I      = 3'd2,
        C_LOAD   = 3'd3,
        C_STORE  = 3'd4,
        C_BRANCH = 3'd5,
        C_MUL    = 3'd6
    } class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_MUL    = 7'b0000001;

    state_e          state_q, state_d;
    class_e          class_q, class_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] instret_q;
    logic            retire;

    // Map an opcode to an instruction class; C_NONE means the instruction traps.
    function automatic class_e classify(input logic [6:0] op, input logic [6:0] f7);
        class_e c;
        case (op)
            OP_R: begin
                if (f7 == F7_MUL) begin
`ifdef MC_CTRL_MUL_EN
                    c = C_MUL;
`else
                    c = C_NONE;
`endif
                end else begin
                    c = C_R;
                end
            end
            OP_I:      c = C_I;
            OP_LOAD:   c = C_LOAD;
            OP_STORE:  c = C_STORE;
            OP_BRANCH: c = C_BRANCH;
            default:   c = C_NONE;
        endcase
        return c;
    endfunction

    // State, class, multiply wait counter and sticky illegal flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            class_q   <= C_NONE;
            cnt_q     <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Retired-instruction counter; wraps naturally at 2^XLEN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + XLEN'(1);
        end
    end

    // Next-state and control outputs; outputs depend on state/class plus the handshake inputs only.
    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        cnt_d      = cnt_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        ifetch_req = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUOp      = 2'b00;
        ALUSrc     = 1'b0;
        MemToReg   = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;

        case (state_q)
            S_FETCH: begin
                ifetch_req = 1'b1;
                if (imem_rdy) begin
                    IRWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                class_d = classify(opcode, funct7);
                state_d = (class_d == C_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (class_q)
                    C_R: begin
                        ALUOp   = 2'b10;
                        state_d = S_WB;
                    end
                    C_I: begin
                        ALUOp   = 2'b10;
                        ALUSrc  = 1'b1;
                        state_d = S_WB;
                    end
                    C_MUL: begin
                        ALUOp   = 2'b10;
                        cnt_d   = 4'(MUL_LAT);
                        state_d = S_MULW;
                    end
                    C_LOAD, C_STORE: begin
                        ALUSrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    C_BRANCH: begin
                        ALUOp   = 2'b01;
                        PCWrite = 1'b1;
                        PCSrc   = br_taken;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                MemRead  = (class_q == C_LOAD);
                MemWrite = (class_q == C_STORE);
                if (class_q != C_LOAD && class_q != C_STORE) begin
                    state_d = S_TRAP;
                end else if (dmem_rdy) begin
                    if (class_q == C_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        PCWrite = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemToReg = (class_q == C_LOAD);
                PCWrite  = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MULW: begin
                ALUOp = 2'b10;
                if (cnt_q <= 4'd1) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        if (state_d == S_TRAP) begin
            illegal_d = 1'b1;
        end

        // Reset holds every strobe low and aborts the in-flight instruction.
        if (rst) begin
            retire     = 1'b0;
            ifetch_req = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            ALUOp      = 2'b00;
            ALUSrc     = 1'b0;
            MemToReg   = 1'b0;
            PCWrite    = 1'b0;
            PCSrc      = 1'b0;
        end
    end

    assign illegal = illegal_q;
    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard testbench for multicycle_control
module tb_multicycle_control;

    localparam int TB_XLEN    = 4;
    localparam int TB_MUL_LAT = 4;
`ifdef MC_CTRL_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_MUL = 5, K_ILL = 6;

    typedef struct packed {
        logic       ifetch, irw, regw, mrd, mwr;
        logic [1:0] aluop;
        logic       alusrc, m2r, pcw, pcs, ill;
    } outs_t;

    typedef struct packed {
        logic [6:0]         op;
        logic [6:0]         f7;
        logic               imem, dmem, br;
        logic [2:0]         st;
        outs_t              o;
        logic [TB_XLEN-1:0] ir;
    } cyc_t;

    logic               clk, rst;
    logic [6:0]         opcode, funct7;
    logic               imem_rdy, dmem_rdy, br_taken;
    logic               ifetch_req, IRWrite, RegWrite, MemRead, MemWrite;
    logic [1:0]         ALUOp;
    logic               ALUSrc, MemToReg, PCWrite, PCSrc, illegal;
    logic [2:0]         state;
    logic [TB_XLEN-1:0] instret;
    logic [11:0]        dut_outs;

    int                 checks, errors, step;
    logic [TB_XLEN-1:0] ir_m;
    cyc_t               stim_q[$];
    cyc_t               sb_q[$];

    multicycle_control #(.XLEN(TB_XLEN), .MUL_LAT(TB_MUL_LAT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct7(funct7),
        .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .br_taken(br_taken),
        .ifetch_req(ifetch_req), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
        .MemToReg(MemToReg), .PCWrite(PCWrite), .PCSrc(PCSrc), .illegal(illegal),
        .state(state), .instret(instret)
    );

    assign dut_outs = {ifetch_req, IRWrite, RegWrite, MemRead, MemWrite, ALUOp,
                       ALUSrc, MemToReg, PCWrite, PCSrc, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cyc_t blank(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] st);
        cyc_t c;
        c.op   = op;
        c.f7   = f7;
        c.imem = 1'($urandom);
        c.dmem = 1'($urandom);
        c.br   = 1'($urandom);
        c.st   = st;
        c.o    = '0;
        c.ir   = ir_m;
        return c;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, derived from the state table.
    task automatic gen(input logic [6:0] op, input logic [6:0] f7, input int iw, input int dw,
                       input logic br, input int trap_len);
        cyc_t c;
        int   k;
        case (op)
            OP_R:      k = (f7 == 7'b0000001) ? (MUL_ON ? K_MUL : K_ILL) : K_R;
            OP_I:      k = K_I;
            OP_LOAD:   k = K_LD;
            OP_STORE:  k = K_ST;
            OP_BRANCH: k = K_BR;
            default:   k = K_ILL;
        endcase
        for (int i = 0; i <= iw; i++) begin
            c = blank(op, f7, 3'd0);
            c.imem     = (i == iw);
            c.o.ifetch = 1'b1;
            c.o.irw    = (i == iw);
            stim_q.push_back(c);
        end
        stim_q.push_back(blank(op, f7, 3'd1));
        if (k == K_ILL) begin
            for (int i = 0; i < trap_len; i++) begin
                c = blank(op, f7, 3'd5);
                c.o.ill = 1'b1;
                stim_q.push_back(c);
            end
            return;
        end
        c = blank(op, f7, 3'd2);
        if (k == K_BR) begin
            c.br      = br;
            c.o.aluop = 2'b01;
            c.o.pcw   = 1'b1;
            c.o.pcs   = br;
            stim_q.push_back(c);
            ir_m++;
            return;
        end
        c.o.aluop  = (k == K_LD || k == K_ST) ? 2'b00 : 2'b10;
        c.o.alusrc = (k == K_I || k == K_LD || k == K_ST);
        stim_q.push_back(c);
        if (k == K_MUL) begin
            for (int i = 0; i < TB_MUL_LAT; i++) begin
                c = blank(op, f7, 3'd6);
                c.o.aluop = 2'b10;
                stim_q.push_back(c);
            end
        end
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i <= dw; i++) begin
                c = blank(op, f7, 3'd3);
                c.dmem  = (i == dw);
                c.o.mrd = (k == K_LD);
                c.o.mwr = (k == K_ST);
                c.o.pcw = (k == K_ST) && (i == dw);
                stim_q.push_back(c);
            end
            if (k == K_ST) begin
                ir_m++;
                return;
            end
        end
        c = blank(op, f7, 3'd4);
        c.o.regw = 1'b1;
        c.o.m2r  = (k == K_LD);
        c.o.pcw  = 1'b1;
        stim_q.push_back(c);
        ir_m++;
    endtask

    task automatic run_n(input int n);
        cyc_t c, e;
        for (int i = 0; i < n && stim_q.size() > 0; i++) begin
            c = stim_q.pop_front();
            @(negedge clk);
            opcode   = c.op;
            funct7   = c.f7;
            imem_rdy = c.imem;
            dmem_rdy = c.dmem;
            br_taken = c.br;
            sb_q.push_back(c);
            #1;
            e = sb_q.pop_front();
            step++;
            check($sformatf("state#%0d", step), 64'(state), 64'(e.st));
            check($sformatf("outs#%0d", step), 64'(dut_outs), 64'(e.o));
            check($sformatf("instret#%0d", step), 64'(instret), 64'(e.ir));
        end
    endtask

    task automatic run_all();
        run_n(stim_q.size());
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst      = 1'b1;
        imem_rdy = 1'b0;
        dmem_rdy = 1'b0;
        br_taken = 1'b0;
        #1;
        check({tag, "_state"}, 64'(state), 64'd0);
        check({tag, "_outs"}, 64'(dut_outs), 64'd0);
        check({tag, "_instret"}, 64'(instret), 64'd0);
        @(negedge clk);
        #1;
        check({tag, "_held_state"}, 64'(state), 64'd0);
        check({tag, "_held_outs"}, 64'(dut_outs), 64'd0);
        rst  = 1'b0;
        ir_m = '0;
    endtask

    initial begin
        logic [6:0] ops [5];
        logic [6:0] op, f7;
        checks   = 0;
        errors   = 0;
        step     = 0;
        ir_m     = '0;
        rst      = 1'b1;
        opcode   = '0;
        funct7   = '0;
        imem_rdy = 1'b0;
        dmem_rdy = 1'b0;
        br_taken = 1'b0;
        ops      = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};

        do_reset("por");

        gen(OP_R, 7'd0, 0, 0, 1'b0, 0);
        gen(OP_LOAD, 7'd5, 0, 3, 1'b0, 0);
        gen(OP_BRANCH, 7'd0, 0, 0, 1'b1, 0);
        gen(OP_BRANCH, 7'd0, 1, 0, 1'b0, 0);
        gen(OP_I, 7'h20, 2, 0, 1'b0, 0);
        gen(OP_STORE, 7'd0, 1, 0, 1'b0, 0);
        gen(OP_STORE, 7'd0, 0, 2, 1'b0, 0);
        gen(OP_LOAD, 7'd0, 0, 0, 1'b0, 0);
        run_all();

        for (int n = 0; n < 20; n++) begin
            op = ops[$urandom_range(0, 4)];
            f7 = 7'($urandom);
            if (op == OP_R && f7 == 7'b0000001) f7 = 7'd0;
            gen(op, f7, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), 0);
        end
        run_all();

        gen(OP_R, 7'b0000001, 0, 0, 1'b0, 6);
        run_all();
        do_reset("after_mul");

        gen(7'b1111111, 7'd0, 0, 0, 1'b0, 20);
        run_all();
        do_reset("trap");

        gen(OP_R, 7'd0, 0, 0, 1'b0, 0);
        run_all();
        gen(OP_STORE, 7'd0, 0, 6, 1'b0, 0);
        run_n(6);
        stim_q.delete();
        do_reset("abort");
        gen(OP_R, 7'd0, 0, 0, 1'b0, 0);
        run_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
